// File: rtl/fp_addsub_ctrl.sv
// Multi-cycle binary32 add/subtract unit with a valid/ready handshake.
// Special operands (zero/inf/NaN) short-circuit through Special_Add; the rest align, add and normalise with RTZ.

module Special_Add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_symbol,
  output logic        o_check_special,
  output logic [31:0] o_out
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic w_b_s;
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
  assign w_b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
  assign w_a_inf  = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
  assign w_b_inf  = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
  assign w_a_zero = (i_a[30:0] == 31'd0);
  assign w_b_zero = (i_b[30:0] == 31'd0);

  always_comb begin
    w_b_s           = i_b[31] ^ i_symbol;
    o_check_special = 1'b1;
    o_out           = 32'h0;
    if (w_a_nan || w_b_nan)      o_out = QNAN;
    else if (w_a_inf && w_b_inf) o_out = (i_a[31] == w_b_s) ? i_a : QNAN;
    else if (w_a_inf)            o_out = i_a;
    else if (w_b_inf)            o_out = {w_b_s, i_b[30:0]};
    else if (w_a_zero && w_b_zero) o_out = {i_a[31] & w_b_s, 31'h0};
    else if (w_a_zero)           o_out = {w_b_s, i_b[30:0]};
    else if (w_b_zero)           o_out = i_a;
    else                         o_check_special = 1'b0;
  end
endmodule

module fp_addsub_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        symbol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        special,
  output logic        busy
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_a, r_b, r_result;
  logic        r_special, r_out_valid;
  logic        r_sign_l, r_sign_s;
  logic [8:0]  r_exp;
  logic [26:0] r_man_a, r_man_b;
  logic [7:0]  r_d;
  logic [27:0] r_sum;

  logic        w_spec;
  logic [31:0] w_spec_out;
  logic        w_a_ge_b;
  logic [31:0] w_l, w_s;
  logic [7:0]  w_d_chk;
  logic [27:0] w_sum;
  logic        w_add_done;
  logic [31:0] w_add_res;
  logic [27:0] w_norm_man;
  logic [8:0]  w_norm_exp;
  logic        w_norm_done;

  function automatic logic [31:0] flush_dn(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? {x[31], 31'h0} : x;
  endfunction

  // Round-toward-zero pack: G/R/S already excluded from frac; overflow saturates to max finite.
  function automatic logic [31:0] pack(input logic sign, input logic [8:0] exp, input logic [22:0] frac);
    if (exp >= 9'd255)    return {sign, 31'h7F7F_FFFF};
    else if (exp == 9'd0) return {sign, 31'h0};
    else                  return {sign, exp[7:0], frac};
  endfunction

  Special_Add u_special (
    .i_a             (r_a),
    .i_b             (r_b),
    .i_symbol        (1'b0),
    .o_check_special (w_spec),
    .o_out           (w_spec_out)
  );

  assign w_a_ge_b = (r_a[30:0] >= r_b[30:0]);
  assign w_l      = w_a_ge_b ? r_a : r_b;
  assign w_s      = w_a_ge_b ? r_b : r_a;
  assign w_d_chk  = w_l[30:23] - w_s[30:23];

  // Larger magnitude is always in r_man_a, so the subtraction never goes negative.
  assign w_sum = (r_sign_l == r_sign_s) ? ({1'b0, r_man_a} + {1'b0, r_man_b})
                                        : ({1'b0, r_man_a} - {1'b0, r_man_b});
  assign w_add_done = (w_sum == 28'd0) || (w_sum[27:26] == 2'b01);
  assign w_add_res  = (w_sum == 28'd0) ? 32'h0 : pack(r_sign_l, r_exp, w_sum[25:3]);

  always_comb begin
    w_norm_man  = {r_sum[26:0], 1'b0};
    w_norm_exp  = r_exp - 9'd1;
    w_norm_done = 1'b0;
    if (r_sum[27]) begin
      w_norm_man  = {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
      w_norm_exp  = r_exp + 9'd1;
      w_norm_done = 1'b1;
    end else begin
      w_norm_done = w_norm_man[26] || (w_norm_exp == 9'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_spec)               w_state_nxt = S_DONE;
        else if (w_d_chk == 8'd0) w_state_nxt = S_ADD;
        else                      w_state_nxt = S_ALIGN;
      end
      S_ALIGN: if (r_d > 8'd26 || r_d == 8'd1) w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = w_add_done ? S_DONE : S_NORM;
      S_NORM:  if (w_norm_done) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    out_valid = r_out_valid;
    result    = r_result;
    special   = r_special;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_result    <= 32'h0;
      r_special   <= 1'b0;
      r_out_valid <= 1'b0;
      r_sign_l    <= 1'b0;
      r_sign_s    <= 1'b0;
      r_exp       <= 9'd0;
      r_man_a     <= 27'd0;
      r_man_b     <= 27'd0;
      r_d         <= 8'd0;
      r_sum       <= 28'd0;
    end else begin
      r_out_valid <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= flush_dn(a);
            r_b <= flush_dn({b[31] ^ symbol, b[30:0]});
          end
        end
        S_CHECK: begin
          if (w_spec) begin
            r_result  <= w_spec_out;
            r_special <= 1'b1;
          end else begin
            r_sign_l <= w_l[31];
            r_sign_s <= w_s[31];
            r_exp    <= {1'b0, w_l[30:23]};
            r_man_a  <= {1'b1, w_l[22:0], 3'b000};
            r_man_b  <= {1'b1, w_s[22:0], 3'b000};
            r_d      <= w_d_chk;
          end
        end
        S_ALIGN: begin
          // Beyond 26 places every bit of B lands in sticky, so collapse in one step.
          if (r_d > 8'd26) begin
            r_man_b <= 27'd1;
            r_d     <= 8'd0;
          end else begin
            r_man_b <= {1'b0, r_man_b[26:2], r_man_b[1] | r_man_b[0]};
            r_d     <= r_d - 8'd1;
          end
        end
        S_ADD: begin
          r_sum <= w_sum;
          if (w_add_done) begin
            r_result  <= w_add_res;
            r_special <= 1'b0;
          end
        end
        S_NORM: begin
          r_sum <= w_norm_man;
          r_exp <= w_norm_exp;
          if (w_norm_done) begin
            r_result  <= pack(r_sign_l, w_norm_exp, w_norm_man[25:3]);
            r_special <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Directed self-checking bench for fp_addsub_ctrl: values, latencies, backpressure and mid-operation reset.
module tb_fp_addsub_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        symbol = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        in_ready, out_valid, special, busy;
  logic [31:0] result;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_addsub_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .symbol    (symbol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .special   (special),
    .busy      (busy)
  );

  // Issue one op; lat counts clock edges from the accept edge (=1) to first out_valid.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isym,
                        output logic [31:0] res, output logic sp, output int lat);
    @(negedge clk);
    a = ia; b = ib; symbol = isym; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; symbol = ~isym;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result;
    sp  = special;
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 32'h0)    begin failures++; $display("FAIL rst_result got %h exp 00000000", result); end
    checks++; if (special !== 1'b0)    begin failures++; $display("FAIL rst_special got %b exp 0", special); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [31:0] r; logic s; int l;
    run_op(32'h406CCCCD, 32'h406CCCCD, 1'b0, r, s, l);
    checks++; if (r !== 32'h40ECCCCD) begin failures++; $display("FAIL add_result got %h exp 40eccccd", r); end
    checks++; if (s !== 1'b0)         begin failures++; $display("FAIL add_special got %b exp 0", s); end
    checks++; if (l != 4)             begin failures++; $display("FAIL add_latency got %0d exp 4", l); end
    checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL add_in_ready_done got %b exp 0", in_ready); end
    release_out();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL add_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_sub_zero;
    logic [31:0] r; logic s; int l;
    run_op(32'h406CCCCD, 32'h406CCCCD, 1'b1, r, s, l);
    checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL subz_result got %h exp 00000000", r); end
    checks++; if (s !== 1'b0)          begin failures++; $display("FAIL subz_special got %b exp 0", s); end
    checks++; if (l != 3)              begin failures++; $display("FAIL subz_latency got %0d exp 3", l); end
    release_out();
  endtask

  task automatic test_special;
    logic [31:0] r; logic s; int l;
    run_op(32'h7F800000, 32'hFF800000, 1'b0, r, s, l);
    checks++; if (r[30:23] !== 8'hFF || r[22:0] == 23'd0)
      begin failures++; $display("FAIL spec_nan got %h exp exp=ff frac!=0", r); end
    checks++; if (s !== 1'b1) begin failures++; $display("FAIL spec_nan_special got %b exp 1", s); end
    checks++; if (l != 2)     begin failures++; $display("FAIL spec_nan_latency got %0d exp 2", l); end
    release_out();
    run_op(32'h0000_0000, 32'hC06CCCCD, 1'b1, r, s, l);
    checks++; if (r !== 32'h406CCCCD) begin failures++; $display("FAIL spec_zero_result got %h exp 406ccccd", r); end
    checks++; if (s !== 1'b1)         begin failures++; $display("FAIL spec_zero_special got %b exp 1", s); end
    checks++; if (l != 2)             begin failures++; $display("FAIL spec_zero_latency got %0d exp 2", l); end
    release_out();
    // A denormal operand is flushed to zero, so 1.0 passes straight through the special path.
    run_op(32'h0000_0001, 32'h3F800000, 1'b0, r, s, l);
    checks++; if (r !== 32'h3F800000 || s !== 1'b1)
      begin failures++; $display("FAIL spec_denorm got %h/%b exp 3f800000/1", r, s); end
    release_out();
  endtask

  task automatic test_align;
    logic [31:0] r; logic s; int l;
    run_op(32'h3F800000, 32'h30800000, 1'b0, r, s, l);
    checks++; if (r !== 32'h3F800000) begin failures++; $display("FAIL align30_result got %h exp 3f800000", r); end
    checks++; if (l != 4)             begin failures++; $display("FAIL align30_latency got %0d exp 4", l); end
    release_out();
    run_op(32'h3F800000, 32'h33800000, 1'b1, r, s, l);
    checks++; if (r !== 32'h3F7FFFFF) begin failures++; $display("FAIL align24_result got %h exp 3f7fffff", r); end
    checks++; if (s !== 1'b0)         begin failures++; $display("FAIL align24_special got %b exp 0", s); end
    checks++; if (l != 28)            begin failures++; $display("FAIL align24_latency got %0d exp 28", l); end
    release_out();
  endtask

  task automatic test_overflow;
    logic [31:0] r; logic s; int l;
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, s, l);
    checks++; if (r !== 32'h7F7FFFFF) begin failures++; $display("FAIL ovf_result got %h exp 7f7fffff", r); end
    checks++; if (l != 4)             begin failures++; $display("FAIL ovf_latency got %0d exp 4", l); end
    release_out();
  endtask

  task automatic test_backpressure;
    logic [31:0] r; logic s; int l;
    run_op(32'h406CCCCD, 32'h406CCCCD, 1'b0, r, s, l);
    checks++; if (r !== 32'h40ECCCCD) begin failures++; $display("FAIL bp_first got %h exp 40eccccd", r); end
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000; symbol = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== 32'h40ECCCCD || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle %0d got res=%h ov=%b ir=%b busy=%b exp 40eccccd/1/0/1",
                 i, result, out_valid, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    release_out();
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h33800000; symbol = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL midrst_ctrl got ir=%b busy=%b exp 1/0", in_ready, busy); end
    checks++; if (out_valid !== 1'b0 || special !== 1'b0 || result !== 32'h0)
      begin failures++; $display("FAIL midrst_out got ov=%b sp=%b res=%h exp 0/0/00000000", out_valid, special, result); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_output got %0d pulses exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_special();
    test_align();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_add();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
